mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two requesters, the arbiter and memory port 2.
// master = arbiter view; slave = requesters plus memory view.
interface mem_port_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic        req0_we;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic        req1_valid;
    logic        req1_ready;
    logic        req1_we;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic        resp0_valid;
    logic [31:0] resp0_rdata;
    logic        resp0_err;
    logic        resp1_valid;
    logic [31:0] resp1_rdata;
    logic        resp1_err;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_write_enable;
    logic [31:0] mem_rdata;
    logic        busy;

    modport master (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, req1_ready,
        output resp0_valid, resp0_rdata, resp0_err,
        output resp1_valid, resp1_rdata, resp1_err,
        output mem_address, mem_wdata, mem_write_enable, busy
    );

    modport slave (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp0_rdata, resp0_err,
        input  resp1_valid, resp1_rdata, resp1_err,
        input  mem_address, mem_wdata, mem_write_enable, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising CPU and loader accesses onto memory port 2.
//   state  | meaning
//   IDLE   | grant a requester, accept one request
//   ACCESS | drive address/data, pulse write enable once
//   WAIT   | hold address while read latency counts down
//   RESP   | one-cycle response pulse to the owner
module mem_port_arbiter #(
    parameter int NUM_BYTES        = 64,
    parameter int MEM_READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_arbiter_if.master    bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [31:0] MAX_ADDR = 32'(NUM_BYTES - 4);
    localparam logic [1:0]  LAT      = 2'(MEM_READ_LATENCY);

    state_t      state, state_nxt;
    logic        last_grant;
    logic        owner_q, we_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  cnt_q;

    logic        grant, ready0, ready1, hs, hs_we, hs_err, in_access;
    logic [31:0] hs_addr, hs_wdata;

    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid)
            grant = ~last_grant;
        else if (bus.req1_valid)
            grant = 1'b1;

        ready0   = (state == IDLE) && bus.req0_valid && !grant;
        ready1   = (state == IDLE) && bus.req1_valid && grant;
        hs       = ready0 || ready1;
        hs_we    = grant ? bus.req1_we    : bus.req0_we;
        hs_addr  = grant ? bus.req1_addr  : bus.req0_addr;
        hs_wdata = grant ? bus.req1_wdata : bus.req0_wdata;
        hs_err   = (hs_addr[1:0] != 2'b00) || (hs_addr > MAX_ADDR);

        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ACCESS;
            ACCESS:  state_nxt = (we_q || err_q || (LAT == 2'd0)) ? RESP : WAIT;
            WAIT:    if (cnt_q == 2'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        in_access            = (state == ACCESS) || (state == WAIT);
        bus.req0_ready       = ready0;
        bus.req1_ready       = ready1;
        bus.mem_address      = in_access ? addr_q  : 32'd0;
        bus.mem_wdata        = in_access ? wdata_q : 32'd0;
        bus.mem_write_enable = (state == ACCESS) && we_q && !err_q;
        bus.resp0_valid      = (state == RESP) && !owner_q;
        bus.resp1_valid      = (state == RESP) && owner_q;
        bus.resp0_rdata      = bus.resp0_valid ? rdata_q : 32'd0;
        bus.resp1_rdata      = bus.resp1_valid ? rdata_q : 32'd0;
        bus.resp0_err        = bus.resp0_valid && err_q;
        bus.resp1_err        = bus.resp1_valid && err_q;
        bus.busy             = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // rdata_q is cleared at accept so writes and errored accesses answer with 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            cnt_q      <= 2'd0;
        end else begin
            if (hs) begin
                owner_q    <= grant;
                last_grant <= grant;
                we_q       <= hs_we;
                err_q      <= hs_err;
                addr_q     <= hs_addr;
                wdata_q    <= hs_wdata;
                rdata_q    <= 32'd0;
            end
            if ((state == ACCESS) && !we_q && !err_q) begin
                if (LAT == 2'd0)
                    rdata_q <= bus.mem_rdata;
                else
                    cnt_q <= LAT;
            end
            if (state == WAIT) begin
                cnt_q <= cnt_q - 2'd1;
                if (cnt_q == 2'd1)
                    rdata_q <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter per read latency (1, 0, 3) with behavioural memories.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic preload;
    int   checks = 0;
    int   errs   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if if_a();
    mem_port_arbiter_if if_b();
    mem_port_arbiter_if if_c();

    mem_port_arbiter #(.NUM_BYTES(64), .MEM_READ_LATENCY(1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(if_a.master));
    mem_port_arbiter #(.NUM_BYTES(64), .MEM_READ_LATENCY(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if_b.master));
    mem_port_arbiter #(.NUM_BYTES(64), .MEM_READ_LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if_c.master));

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] mem_c [16];
    logic [31:0] pa1, pc1, pc2, pc3;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= 32'h1000_0000 + 32'(i);
                mem_b[i] <= 32'h1000_0000 + 32'(i);
                mem_c[i] <= 32'h1000_0000 + 32'(i);
            end
        end else begin
            if (if_a.mem_write_enable) mem_a[if_a.mem_address[5:2]] <= if_a.mem_wdata;
            if (if_b.mem_write_enable) mem_b[if_b.mem_address[5:2]] <= if_b.mem_wdata;
            if (if_c.mem_write_enable) mem_c[if_c.mem_address[5:2]] <= if_c.mem_wdata;
        end
        pa1 <= mem_a[if_a.mem_address[5:2]];
        pc1 <= mem_c[if_c.mem_address[5:2]];
        pc2 <= pc1;
        pc3 <= pc2;
    end

    assign if_a.mem_rdata = pa1;
    assign if_b.mem_rdata = mem_b[if_b.mem_address[5:2]];
    assign if_c.mem_rdata = pc3;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        if_a.req0_valid = 0; if_a.req0_we = 0; if_a.req0_addr = 0; if_a.req0_wdata = 0;
        if_a.req1_valid = 0; if_a.req1_we = 0; if_a.req1_addr = 0; if_a.req1_wdata = 0;
        if_b.req0_valid = 0; if_b.req0_we = 0; if_b.req0_addr = 0; if_b.req0_wdata = 0;
        if_b.req1_valid = 0; if_b.req1_we = 0; if_b.req1_addr = 0; if_b.req1_wdata = 0;
        if_c.req0_valid = 0; if_c.req0_we = 0; if_c.req0_addr = 0; if_c.req0_wdata = 0;
        if_c.req1_valid = 0; if_c.req1_we = 0; if_c.req1_addr = 0; if_c.req1_wdata = 0;
    endtask

    // single-cycle request on the latency-1 arbiter; returns at the start of T+1
    task automatic issue_a(input int n, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        if (n == 0) begin
            if_a.req0_valid = 1; if_a.req0_we = we; if_a.req0_addr = addr; if_a.req0_wdata = wdata;
        end else begin
            if_a.req1_valid = 1; if_a.req1_we = we; if_a.req1_addr = addr; if_a.req1_wdata = wdata;
        end
        #1;
        chk("ready_own",   (n == 0) ? if_a.req0_ready : if_a.req1_ready, 1);
        chk("ready_other", (n == 0) ? if_a.req1_ready : if_a.req0_ready, 0);
        step;
        if_a.req0_valid = 0;
        if_a.req1_valid = 0;
    endtask

    // checks ACCESS, WAIT cycles and the response landing at T+lat
    task automatic expect_a(input int n, input int lat, input logic [31:0] rdata,
                            input logic err, input logic [31:0] addr, input logic we_exp);
        #1;
        chk("wen_access",  if_a.mem_write_enable, we_exp);
        chk("addr_access", if_a.mem_address, addr);
        chk("busy_access", if_a.busy, 1);
        for (int i = 2; i < lat; i++) begin
            step; #1;
            chk("addr_wait", if_a.mem_address, addr);
            chk("wen_wait",  if_a.mem_write_enable, 0);
            chk("resp_early", if_a.resp0_valid | if_a.resp1_valid, 0);
        end
        step; #1;
        chk("resp_own",   (n == 0) ? if_a.resp0_valid : if_a.resp1_valid, 1);
        chk("resp_other", (n == 0) ? if_a.resp1_valid : if_a.resp0_valid, 0);
        chk("resp_rdata", (n == 0) ? if_a.resp0_rdata : if_a.resp1_rdata, rdata);
        chk("resp_err",   (n == 0) ? if_a.resp0_err   : if_a.resp1_err,   err);
        chk("wen_resp",   if_a.mem_write_enable, 0);
        chk("addr_resp",  if_a.mem_address, 0);
        step;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        preload = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  if_a.busy, 0);
        chk("rst_r0v",   if_a.resp0_valid, 0);
        chk("rst_r1v",   if_a.resp1_valid, 0);
        chk("rst_addr",  if_a.mem_address, 0);
        chk("rst_wen",   if_a.mem_write_enable, 0);
        chk("rst_ready", if_a.req0_ready | if_a.req1_ready, 0);
        preload = 1'b0;
        rst_n   = 1'b1;
        step;

        // write then read back through the latency-1 memory
        issue_a(0, 1, 32'h8, 32'hDEAD_BEEF);
        expect_a(0, 2, 32'h0, 0, 32'h8, 1);
        chk("mem_written", mem_a[2], 32'hDEAD_BEEF);
        issue_a(0, 0, 32'h8, 32'h0);
        expect_a(0, 3, 32'hDEAD_BEEF, 0, 32'h8, 0);

        // reset in the middle of a read
        issue_a(0, 0, 32'h8, 32'h0);
        step;
        chk("wait_busy", if_a.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", if_a.busy, 0);
        chk("rst_mid_addr", if_a.mem_address, 0);
        chk("rst_mid_r0v",  if_a.resp0_valid, 0);
        chk("rst_mid_wen",  if_a.mem_write_enable, 0);
        step;
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            chk("dropped_resp", if_a.resp0_valid | if_a.resp1_valid, 0);
            chk("dropped_busy", if_a.busy, 0);
        end

        // both requesters reading continuously: 0,1,0,1
        if_a.req0_valid = 1; if_a.req0_we = 0; if_a.req0_addr = 32'h8;
        if_a.req1_valid = 1; if_a.req1_we = 0; if_a.req1_addr = 32'h3C;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("rr_ready0", if_a.req0_ready, (g % 2 == 0) ? 1 : 0);
            chk("rr_ready1", if_a.req1_ready, (g % 2 == 1) ? 1 : 0);
            step; #1;
            chk("rr_noready_acc", if_a.req0_ready | if_a.req1_ready, 0);
            step; #1;
            chk("rr_noready_wait", if_a.req0_ready | if_a.req1_ready, 0);
            chk("rr_noresp_wait", if_a.resp0_valid | if_a.resp1_valid, 0);
            step; #1;
            chk("rr_noready_resp", if_a.req0_ready | if_a.req1_ready, 0);
            chk("rr_resp0", if_a.resp0_valid, (g % 2 == 0) ? 1 : 0);
            chk("rr_resp1", if_a.resp1_valid, (g % 2 == 1) ? 1 : 0);
            chk("rr_rdata", (g % 2 == 0) ? if_a.resp0_rdata : if_a.resp1_rdata,
                (g % 2 == 0) ? 32'hDEAD_BEEF : 32'h1000_000F);
            step;
        end
        if_a.req0_valid = 0;
        if_a.req1_valid = 0;
        step;

        // rejected writes leave memory alone
        issue_a(1, 1, 32'h6, 32'h1111_1111);
        expect_a(1, 2, 32'h0, 1, 32'h6, 0);
        issue_a(1, 1, 32'h40, 32'h2222_2222);
        expect_a(1, 2, 32'h0, 1, 32'h40, 0);
        chk("mem1_intact", mem_a[1], 32'h1000_0001);
        chk("mem0_intact", mem_a[0], 32'h1000_0000);

        // address boundary
        issue_a(1, 0, 32'h3C, 32'h0);
        expect_a(1, 3, 32'h1000_000F, 0, 32'h3C, 0);
        issue_a(1, 0, 32'hFFFF_FFFC, 32'h0);
        expect_a(1, 2, 32'h0, 1, 32'hFFFF_FFFC, 0);

        // latency 0 and latency 3 variants, same read issued together
        if_b.req0_valid = 1; if_b.req0_addr = 32'h10;
        if_c.req0_valid = 1; if_c.req0_addr = 32'h10;
        #1;
        chk("l0_ready", if_b.req0_ready, 1);
        chk("l3_ready", if_c.req0_ready, 1);
        step;
        if_b.req0_valid = 0;
        if_c.req0_valid = 0;
        #1;
        chk("l0_addr", if_b.mem_address, 32'h10);
        chk("l0_noresp", if_b.resp0_valid, 0);
        chk("l3_addr_acc", if_c.mem_address, 32'h10);
        step; #1;
        chk("l0_resp", if_b.resp0_valid, 1);
        chk("l0_rdata", if_b.resp0_rdata, 32'h1000_0004);
        chk("l0_err", if_b.resp0_err, 0);
        for (int i = 0; i < 3; i++) begin
            chk("l3_addr_wait", if_c.mem_address, 32'h10);
            chk("l3_noresp", if_c.resp0_valid, 0);
            step; #1;
        end
        chk("l3_resp", if_c.resp0_valid, 1);
        chk("l3_rdata", if_c.resp0_rdata, 32'h1000_0004);
        chk("l3_r1v", if_c.resp1_valid, 0);
        chk("l0_idle", if_b.busy, 0);
        step;
        chk("l3_idle", if_c.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
